ct_ifu_bht_pre_ctrl: RTL and testbench
======================================

# ct_ifu_bht_pre_ctrl

Sequencing and arbitration controller for the BHT prediction array, a 1024x64 single-port SRAM behind a gated clock. It shares the single port between the IFU prediction read and the BJU counter-update write. After reset, or on a CP0 invalidate, it sweeps the array to a fixed init value. It drives all array control pins and the array clock-enable, and returns read data to the IFU with a valid strobe.

## Interface
- INIT_VAL, default 64'h5555_5555_5555_5555: word written by the init sweep (every 2-bit counter = 2'b01).
- WB_AGE_MAX, default 4: number of cycles a buffered write may wait behind reads before it wins arbitration.

- forever_cpuclk  in  1  sole clock.
- cpurst  in  1  reset, asynchronous, active-high.
- cp0_ifu_bht_en  in  1  predictor enable; 0 blocks read grants.
- cp0_ifu_bht_inv  in  1  one-cycle pulse that requests a full invalidate sweep.
- ifu_bht_rd_req  in  1  read request.
- ifu_bht_rd_index  in  10  read index.
- bht_ifu_rd_gnt  out  1  read issued to the array this cycle (combinational).
- bht_ifu_rd_data_vld  out  1  read data valid (registered).
- bht_ifu_rd_data  out  64  read data; pass-through of bht_pre_data_out.
- bht_ifu_inv_busy  out  1  init pending or sweep in progress.
- bju_bht_upd_vld  in  1  update push.
- bju_bht_upd_index  in  10  update index.
- bju_bht_upd_din  in  64  update data.
- bju_bht_upd_bwen  in  64  update bit-write-enable, active-low per bit.
- bht_pre_array_clk_en  out  1  array gated-clock local enable.
- bht_pred_array_cen_b  out  1  array chip enable, active-low.
- bht_pred_array_gwen  out  1  global write enable, active-low.
- bht_pred_array_index  out  10  array address.
- bht_pred_array_din  out  64  array write data.
- bht_pred_bwen  out  64  array bit-write-enable, active-low.
- bht_pre_data_out  in  64  array Q.

## Operation
- FSM states: IDLE and INIT.
- Reset:
  - state=IDLE, inv_pend=1, sweep counter=0.
  - write buffer empty, age=0, rd_data_vld=0.
  - Outputs during reset: cen_b=1, gwen=1, clk_en=0, rd_gnt=0, bwen all-ones, index=0, din=0, inv_busy=1.
- IDLE with inv_pend=1: no array access; next state INIT; counter=0; inv_pend cleared; write buffer flushed.
- INIT:
  - Each cycle writes INIT_VAL at index=counter, with gwen=0, bwen=0, cen_b=0; counter increments.
  - The write at counter=1023 is the last; then the FSM enters IDLE and inv_busy drops the following cycle.
  - rd_gnt=0 throughout INIT.
  - bju updates arriving during INIT are discarded.
  - cp0_ifu_bht_inv during INIT restarts the counter at 0 on the next cycle.
- cp0_ifu_bht_inv in IDLE sets inv_pend, so the sweep begins 2 cycles after the pulse.
- Write buffer: 2-entry FIFO of {index, din, bwen}.
  - A push occurs on every bju_bht_upd_vld in IDLE with inv_pend=0.
  - There is no bypass; minimum latency from push to array write is 1 cycle.
- Arbitration in IDLE, inv_pend=0, evaluated each cycle:
  - Write the FIFO head if FIFO is non-empty AND (no read request, OR cp0_ifu_bht_en=0, OR count==2, OR age>=WB_AGE_MAX).
  - Otherwise, if ifu_bht_rd_req && cp0_ifu_bht_en: read rd_index with gwen=1, cen_b=0, rd_gnt=1.
  - Otherwise no access (cen_b=1).
- When the FIFO is full (count==2), a pop is guaranteed that cycle, so a simultaneous push is always accepted and no update is ever dropped in IDLE.
- Age counter:
  - 3 bits, saturating.
  - Increments each cycle the head is non-empty and not popped.
  - Clears on pop and on flush.
- bht_pre_array_clk_en = ~cen_b, combinational.
- Write data and bwen come from the FIFO head or the INIT constants; on reads din is don't-care (driven 0) and bwen is all-ones.

## Timing
- A read granted in cycle N gives rd_data_vld=1 in N+1, with rd_data = Q in N+1.
- A write to an index read in the same or earlier cycle is not forwarded; stale prediction reads are architecturally acceptable.
- The init sweep takes exactly 1024 write cycles. From reset deassertion, the first sweep write happens in cycle 1 and the last in cycle 1024; inv_busy=0 from cycle 1025.
- Asserting cpurst mid-sweep aborts the sweep; the sweep restarts from index 0 after release.
- Counter width is 10 bits; it is never observed past 1023 because the FSM leaves INIT on the 1023 write.

## Test plan
- Reset release -> 1024 consecutive writes of 64'h5555… at indexes 0..1023; rd_gnt=0 throughout; inv_busy falls 1025 cycles after release.
- IDLE, read at index 0x3A5 -> cen_b=0, gwen=1, index=0x3A5, rd_gnt=1; rd_data_vld=1 the next cycle with rd_data=Q.
- Single update (index 7, din 0xF0, bwen ~0xF0) with no reads -> array write in the next cycle with index 7, gwen=0, bwen ~0xF0.
- Continuous reads plus one buffered update -> reads are granted for 4 cycles, then the write wins on the 5th (age=4) and rd_gnt=0 in that cycle.
- Two updates pushed under continuous reads -> FIFO full forces a write the next cycle; a third push in that cycle is accepted; all 3 updates reach the array.
- cp0_ifu_bht_inv at sweep index 500 -> sweep restarts at index 0; total completes 1024 writes after the restart; a buffered update is discarded.

Source files
------------

// File: rtl/ct_ifu_bht_pre_ctrl_if.sv
// Signal bundle between the BHT prediction controller and the IFU, BJU and SRAM array.
// The controller takes the slave modport. The surrounding logic takes the master modport.
interface ct_ifu_bht_pre_ctrl_if;
  logic        cp0_ifu_bht_en;
  logic        cp0_ifu_bht_inv;
  logic        ifu_bht_rd_req;
  logic [9:0]  ifu_bht_rd_index;
  logic        bht_ifu_rd_gnt;
  logic        bht_ifu_rd_data_vld;
  logic [63:0] bht_ifu_rd_data;
  logic        bht_ifu_inv_busy;
  logic        bju_bht_upd_vld;
  logic [9:0]  bju_bht_upd_index;
  logic [63:0] bju_bht_upd_din;
  logic [63:0] bju_bht_upd_bwen;
  logic        bht_pre_array_clk_en;
  logic        bht_pred_array_cen_b;
  logic        bht_pred_array_gwen;
  logic [9:0]  bht_pred_array_index;
  logic [63:0] bht_pred_array_din;
  logic [63:0] bht_pred_bwen;
  logic [63:0] bht_pre_data_out;

  modport slave (
    input  cp0_ifu_bht_en, cp0_ifu_bht_inv, ifu_bht_rd_req, ifu_bht_rd_index,
           bju_bht_upd_vld, bju_bht_upd_index, bju_bht_upd_din, bju_bht_upd_bwen,
           bht_pre_data_out,
    output bht_ifu_rd_gnt, bht_ifu_rd_data_vld, bht_ifu_rd_data, bht_ifu_inv_busy,
           bht_pre_array_clk_en, bht_pred_array_cen_b, bht_pred_array_gwen,
           bht_pred_array_index, bht_pred_array_din, bht_pred_bwen
  );

  modport master (
    output cp0_ifu_bht_en, cp0_ifu_bht_inv, ifu_bht_rd_req, ifu_bht_rd_index,
           bju_bht_upd_vld, bju_bht_upd_index, bju_bht_upd_din, bju_bht_upd_bwen,
           bht_pre_data_out,
    input  bht_ifu_rd_gnt, bht_ifu_rd_data_vld, bht_ifu_rd_data, bht_ifu_inv_busy,
           bht_pre_array_clk_en, bht_pred_array_cen_b, bht_pred_array_gwen,
           bht_pred_array_index, bht_pred_array_din, bht_pred_bwen
  );
endinterface

// File: rtl/ct_ifu_bht_pre_ctrl.sv
// BHT prediction array port controller. It runs the init sweep, buffers BJU updates
// in a 2-entry FIFO and arbitrates the single SRAM port between IFU reads and those writes.
module ct_ifu_bht_pre_ctrl #(
  parameter logic [63:0] INIT_VAL   = 64'h5555_5555_5555_5555,
  parameter int          WB_AGE_MAX = 4
) (
  input  logic                      forever_cpuclk,
  input  logic                      cpurst,
  ct_ifu_bht_pre_ctrl_if.slave      bif
);

  typedef enum logic {IDLE, INIT} state_t;

  typedef struct packed {
    logic [9:0]  index;
    logic [63:0] din;
    logic [63:0] bwen;
  } wb_entry_t;

  state_t      state;
  logic        inv_pend;
  logic [9:0]  sweep_cnt;
  wb_entry_t   wb_entry [2];
  logic [1:0]  wb_count;
  logic [2:0]  wb_age;
  logic        rd_data_vld_q;

  logic        arb_en;
  logic        wb_full;
  logic        wb_empty;
  logic        wr_sel;
  logic        rd_sel;
  logic        push;
  wb_entry_t   new_entry;

  logic        cen_b;
  logic        gwen;
  logic [9:0]  arr_index;
  logic [63:0] arr_din;
  logic [63:0] arr_bwen;

  assign arb_en    = (state == IDLE) && !inv_pend;
  assign wb_full   = (wb_count == 2'd2);
  assign wb_empty  = (wb_count == 2'd0);
  assign push      = arb_en && bif.bju_bht_upd_vld;
  assign new_entry = '{index: bif.bju_bht_upd_index,
                       din:   bif.bju_bht_upd_din,
                       bwen:  bif.bju_bht_upd_bwen};

  // A full FIFO always wins, which is what lets a push never be dropped in IDLE.
  assign wr_sel = arb_en && !wb_empty &&
                  (!bif.ifu_bht_rd_req || !bif.cp0_ifu_bht_en || wb_full ||
                   (int'(wb_age) >= WB_AGE_MAX));
  assign rd_sel = arb_en && !wr_sel && bif.ifu_bht_rd_req && bif.cp0_ifu_bht_en;

  always_comb begin
    cen_b     = 1'b1;
    gwen      = 1'b1;
    arr_index = 10'd0;
    arr_din   = 64'd0;
    arr_bwen  = '1;
    if (state == INIT) begin
      cen_b     = 1'b0;
      gwen      = 1'b0;
      arr_index = sweep_cnt;
      arr_din   = INIT_VAL;
      arr_bwen  = 64'd0;
    end else if (wr_sel) begin
      cen_b     = 1'b0;
      gwen      = 1'b0;
      arr_index = wb_entry[0].index;
      arr_din   = wb_entry[0].din;
      arr_bwen  = wb_entry[0].bwen;
    end else if (rd_sel) begin
      cen_b     = 1'b0;
      arr_index = bif.ifu_bht_rd_index;
    end
  end

  assign bif.bht_pred_array_cen_b = cen_b;
  assign bif.bht_pred_array_gwen  = gwen;
  assign bif.bht_pred_array_index = arr_index;
  assign bif.bht_pred_array_din   = arr_din;
  assign bif.bht_pred_bwen        = arr_bwen;
  assign bif.bht_pre_array_clk_en = ~cen_b;
  assign bif.bht_ifu_rd_gnt       = rd_sel;
  assign bif.bht_ifu_rd_data_vld  = rd_data_vld_q;
  assign bif.bht_ifu_rd_data      = bif.bht_pre_data_out;
  assign bif.bht_ifu_inv_busy     = inv_pend || (state == INIT);

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state         <= IDLE;
      inv_pend      <= 1'b1;
      sweep_cnt     <= 10'd0;
      wb_entry[0]   <= '0;
      wb_entry[1]   <= '0;
      wb_count      <= 2'd0;
      wb_age        <= 3'd0;
      rd_data_vld_q <= 1'b0;
    end else begin
      rd_data_vld_q <= rd_sel;
      case (state)
        IDLE: begin
          if (inv_pend) begin
            state     <= INIT;
            sweep_cnt <= 10'd0;
            inv_pend  <= 1'b0;
            wb_count  <= 2'd0;
            wb_age    <= 3'd0;
          end else begin
            if (bif.cp0_ifu_bht_inv) inv_pend <= 1'b1;
            // The head always sits in entry 0; a pop shifts entry 1 down.
            case ({push, wr_sel})
              2'b01: begin
                wb_entry[0] <= wb_entry[1];
                wb_count    <= wb_count - 2'd1;
              end
              2'b10: begin
                wb_entry[wb_count[0]] <= new_entry;
                wb_count              <= wb_count + 2'd1;
              end
              2'b11: begin
                if (wb_full) begin
                  wb_entry[0] <= wb_entry[1];
                  wb_entry[1] <= new_entry;
                end else begin
                  wb_entry[0] <= new_entry;
                end
              end
              default: ;
            endcase
            if (wr_sel || wb_empty) wb_age <= 3'd0;
            else if (wb_age != 3'd7) wb_age <= wb_age + 3'd1;
          end
        end
        INIT: begin
          sweep_cnt <= sweep_cnt + 10'd1;
          if (bif.cp0_ifu_bht_inv) sweep_cnt <= 10'd0;
          else if (sweep_cnt == 10'd1023) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ct_ifu_bht_pre_ctrl.sv
// Directed bench for ct_ifu_bht_pre_ctrl with a behavioural 1024x64 SRAM model.
// It covers the init sweep, reads, buffered writes, aging, a full FIFO and an invalidate restart.
module tb_ct_ifu_bht_pre_ctrl;

  localparam logic [63:0] IV   = 64'h5555_5555_5555_5555;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  int   bad;

  ct_ifu_bht_pre_ctrl_if bif ();

  ct_ifu_bht_pre_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .bif            (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM: Q updates on read edges, writes honour active-low bwen.
  logic [63:0] mem [1024];
  logic [63:0] q;
  assign bif.bht_pre_data_out = q;
  always @(posedge clk) begin
    if (!bif.bht_pred_array_cen_b) begin
      if (bif.bht_pred_array_gwen)
        q <= mem[bif.bht_pred_array_index];
      else
        mem[bif.bht_pred_array_index] <= (mem[bif.bht_pred_array_index] & bif.bht_pred_bwen) |
                                         (bif.bht_pred_array_din & ~bif.bht_pred_bwen);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdReq, input logic [9:0] rdIdx, input logic updVld,
                               input logic [9:0] updIdx, input logic [63:0] updDin,
                               input logic [63:0] updBwen, input logic inv);
    bif.ifu_bht_rd_req    = rdReq;
    bif.ifu_bht_rd_index  = rdIdx;
    bif.bju_bht_upd_vld   = updVld;
    bif.bju_bht_upd_index = updIdx;
    bif.bju_bht_upd_din   = updDin;
    bif.bju_bht_upd_bwen  = updBwen;
    bif.cp0_ifu_bht_inv   = inv;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  function automatic bit sweepOk(input int idx);
    return (bif.bht_pred_array_cen_b === 1'b0) && (bif.bht_pred_array_gwen === 1'b0) &&
           (bif.bht_pred_array_index === 10'(idx)) && (bif.bht_pred_array_din === IV) &&
           (bif.bht_pred_bwen === 64'd0) && (bif.bht_ifu_rd_gnt === 1'b0) &&
           (bif.bht_pre_array_clk_en === 1'b1) && (bif.bht_ifu_inv_busy === 1'b1);
  endfunction

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    bif.cp0_ifu_bht_en = 1'b1;
    applyStimulus(1'b1, 10'h155, 1'b0, 10'd0, 64'd0, ONES, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    checkOutput("rst_cen_b", 64'(bif.bht_pred_array_cen_b), 64'd1);
    checkOutput("rst_gwen", 64'(bif.bht_pred_array_gwen), 64'd1);
    checkOutput("rst_clk_en", 64'(bif.bht_pre_array_clk_en), 64'd0);
    checkOutput("rst_rd_gnt", 64'(bif.bht_ifu_rd_gnt), 64'd0);
    checkOutput("rst_bwen", bif.bht_pred_bwen, ONES);
    checkOutput("rst_index", 64'(bif.bht_pred_array_index), 64'd0);
    checkOutput("rst_din", bif.bht_pred_array_din, 64'd0);
    checkOutput("rst_inv_busy", 64'(bif.bht_ifu_inv_busy), 64'd1);
    checkOutput("rst_rd_vld", 64'(bif.bht_ifu_rd_data_vld), 64'd0);

    // Init sweep after release, with a read request held the whole time
    rst = 1'b0;
    stepClock();
    checkOutput("release_busy", 64'(bif.bht_ifu_inv_busy), 64'd1);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (!sweepOk(i)) bad++;
      stepClock();
    end
    checkOutput("sweep1_bad_cycles", 64'(bad), 64'd0);
    checkOutput("sweep1_done_busy", 64'(bif.bht_ifu_inv_busy), 64'd0);
    checkOutput("sweep1_done_rd_gnt", 64'(bif.bht_ifu_rd_gnt), 64'd1);
    checkOutput("mem0_init", mem[0], IV);
    checkOutput("mem1023_init", mem[1023], IV);
    applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 64'd0, ONES, 1'b0);
    stepClock();

    // Read at 0x3A5
    applyStimulus(1'b1, 10'h3A5, 1'b0, 10'd0, 64'd0, ONES, 1'b0);
    checkOutput("rd_cen_b", 64'(bif.bht_pred_array_cen_b), 64'd0);
    checkOutput("rd_gwen", 64'(bif.bht_pred_array_gwen), 64'd1);
    checkOutput("rd_index", 64'(bif.bht_pred_array_index), 64'h3A5);
    checkOutput("rd_gnt", 64'(bif.bht_ifu_rd_gnt), 64'd1);
    checkOutput("rd_bwen", bif.bht_pred_bwen, ONES);
    checkOutput("rd_din", bif.bht_pred_array_din, 64'd0);
    stepClock();
    applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 64'd0, ONES, 1'b0);
    checkOutput("rd_vld", 64'(bif.bht_ifu_rd_data_vld), 64'd1);
    checkOutput("rd_data", bif.bht_ifu_rd_data, IV);
    checkOutput("rd_idle_cen_b", 64'(bif.bht_pred_array_cen_b), 64'd1);

    // Predictor disabled blocks the read grant
    bif.cp0_ifu_bht_en = 1'b0;
    applyStimulus(1'b1, 10'h3A5, 1'b0, 10'd0, 64'd0, ONES, 1'b0);
    checkOutput("dis_rd_gnt", 64'(bif.bht_ifu_rd_gnt), 64'd0);
    checkOutput("dis_cen_b", 64'(bif.bht_pred_array_cen_b), 64'd1);
    stepClock();
    bif.cp0_ifu_bht_en = 1'b1;
    applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 64'd0, ONES, 1'b0);
    checkOutput("dis_rd_vld", 64'(bif.bht_ifu_rd_data_vld), 64'd0);

    // Single update with no reads: written one cycle after the push
    applyStimulus(1'b0, 10'd0, 1'b1, 10'd7, 64'hF0, ~64'hF0, 1'b0);
    checkOutput("upd_push_cen_b", 64'(bif.bht_pred_array_cen_b), 64'd1);
    stepClock();
    applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 64'd0, ONES, 1'b0);
    checkOutput("upd_cen_b", 64'(bif.bht_pred_array_cen_b), 64'd0);
    checkOutput("upd_gwen", 64'(bif.bht_pred_array_gwen), 64'd0);
    checkOutput("upd_index", 64'(bif.bht_pred_array_index), 64'd7);
    checkOutput("upd_din", bif.bht_pred_array_din, 64'hF0);
    checkOutput("upd_bwen", bif.bht_pred_bwen, ~64'hF0);
    stepClock();
    checkOutput("upd_after_cen_b", 64'(bif.bht_pred_array_cen_b), 64'd1);
    applyStimulus(1'b1, 10'd7, 1'b0, 10'd0, 64'd0, ONES, 1'b0);
    stepClock();
    applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 64'd0, ONES, 1'b0);
    checkOutput("upd_readback", bif.bht_ifu_rd_data, 64'h5555_5555_5555_55F5);

    // Continuous reads with one buffered update: the write wins once age reaches 4
    applyStimulus(1'b1, 10'h10, 1'b1, 10'h20, ONES, 64'd0, 1'b0);
    checkOutput("age_push_rd_gnt", 64'(bif.bht_ifu_rd_gnt), 64'd1);
    stepClock();
    applyStimulus(1'b1, 10'h10, 1'b0, 10'd0, 64'd0, ONES, 1'b0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (bif.bht_ifu_rd_gnt !== 1'b1 || bif.bht_pred_array_gwen !== 1'b1) bad++;
      stepClock();
    end
    checkOutput("age_read_bad_cycles", 64'(bad), 64'd0);
    checkOutput("age_wr_rd_gnt", 64'(bif.bht_ifu_rd_gnt), 64'd0);
    checkOutput("age_wr_gwen", 64'(bif.bht_pred_array_gwen), 64'd0);
    checkOutput("age_wr_index", 64'(bif.bht_pred_array_index), 64'h20);
    stepClock();
    checkOutput("age_resume_rd_gnt", 64'(bif.bht_ifu_rd_gnt), 64'd1);
    applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 64'd0, ONES, 1'b0);
    stepClock();
    checkOutput("age_mem", mem[10'h20], ONES);

    // Three updates under continuous reads: full FIFO forces writes
    applyStimulus(1'b1, 10'h40, 1'b1, 10'h31, 64'h1111_1111_1111_1111, 64'd0, 1'b0);
    checkOutput("full_a0_rd_gnt", 64'(bif.bht_ifu_rd_gnt), 64'd1);
    stepClock();
    applyStimulus(1'b1, 10'h40, 1'b1, 10'h32, 64'h2222_2222_2222_2222, 64'd0, 1'b0);
    checkOutput("full_a1_rd_gnt", 64'(bif.bht_ifu_rd_gnt), 64'd1);
    stepClock();
    applyStimulus(1'b1, 10'h40, 1'b1, 10'h33, 64'h3333_3333_3333_3333, 64'd0, 1'b0);
    checkOutput("full_a2_rd_gnt", 64'(bif.bht_ifu_rd_gnt), 64'd0);
    checkOutput("full_a2_index", 64'(bif.bht_pred_array_index), 64'h31);
    checkOutput("full_a2_din", bif.bht_pred_array_din, 64'h1111_1111_1111_1111);
    stepClock();
    applyStimulus(1'b1, 10'h40, 1'b0, 10'd0, 64'd0, ONES, 1'b0);
    checkOutput("full_a3_gwen", 64'(bif.bht_pred_array_gwen), 64'd0);
    checkOutput("full_a3_index", 64'(bif.bht_pred_array_index), 64'h32);
    stepClock();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (bif.bht_ifu_rd_gnt !== 1'b1) bad++;
      stepClock();
    end
    checkOutput("full_read_bad_cycles", 64'(bad), 64'd0);
    checkOutput("full_a8_gwen", 64'(bif.bht_pred_array_gwen), 64'd0);
    checkOutput("full_a8_index", 64'(bif.bht_pred_array_index), 64'h33);
    stepClock();
    applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 64'd0, ONES, 1'b0);
    stepClock();
    checkOutput("full_mem31", mem[10'h31], 64'h1111_1111_1111_1111);
    checkOutput("full_mem32", mem[10'h32], 64'h2222_2222_2222_2222);
    checkOutput("full_mem33", mem[10'h33], 64'h3333_3333_3333_3333);

    // Invalidate with an update buffered, then another invalidate at sweep index 500
    applyStimulus(1'b1, 10'h40, 1'b1, 10'h50, 64'hAAAA_AAAA_AAAA_AAAA, 64'd0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 10'h40, 1'b0, 10'd0, 64'd0, ONES, 1'b1);
    checkOutput("inv_pulse_rd_gnt", 64'(bif.bht_ifu_rd_gnt), 64'd1);
    checkOutput("inv_pulse_busy", 64'(bif.bht_ifu_inv_busy), 64'd0);
    stepClock();
    applyStimulus(1'b1, 10'h40, 1'b0, 10'd0, 64'd0, ONES, 1'b0);
    checkOutput("inv_pend_cen_b", 64'(bif.bht_pred_array_cen_b), 64'd1);
    checkOutput("inv_pend_busy", 64'(bif.bht_ifu_inv_busy), 64'd1);
    stepClock();
    bad = 0;
    for (int i = 0; i <= 500; i++) begin
      if (!sweepOk(i)) bad++;
      if (i == 500) bif.cp0_ifu_bht_inv = 1'b1;
      stepClock();
    end
    bif.cp0_ifu_bht_inv = 1'b0;
    checkOutput("sweep2_pre_bad_cycles", 64'(bad), 64'd0);
    checkOutput("sweep2_restart_index", 64'(bif.bht_pred_array_index), 64'd0);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (!sweepOk(i)) bad++;
      bif.bju_bht_upd_vld   = (i == 200);
      bif.bju_bht_upd_index = 10'h60;
      bif.bju_bht_upd_din   = ONES;
      bif.bju_bht_upd_bwen  = 64'd0;
      if (i == 1023) bif.ifu_bht_rd_req = 1'b0;
      stepClock();
    end
    checkOutput("sweep2_bad_cycles", 64'(bad), 64'd0);
    checkOutput("sweep2_done_busy", 64'(bif.bht_ifu_inv_busy), 64'd0);
    checkOutput("discard_idle0_cen_b", 64'(bif.bht_pred_array_cen_b), 64'd1);
    stepClock();
    checkOutput("discard_idle1_cen_b", 64'(bif.bht_pred_array_cen_b), 64'd1);
    applyStimulus(1'b1, 10'h20, 1'b0, 10'd0, 64'd0, ONES, 1'b0);
    stepClock();
    applyStimulus(1'b1, 10'h60, 1'b0, 10'd0, 64'd0, ONES, 1'b0);
    checkOutput("resweep_rd_20", bif.bht_ifu_rd_data, IV);
    stepClock();
    applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 64'd0, ONES, 1'b0);
    checkOutput("resweep_rd_60", bif.bht_ifu_rd_data, IV);
    checkOutput("mem50_discarded", mem[10'h50], IV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
